fp_mul_round_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined result stage for the FP multiplier datapath.
//  - Takes the raw mantissa product, the unbiased exponent sum and the operand signs.
//  - Normalises, rounds to nearest-even, re-biases and detects overflow/underflow.
//  - Packs the IEEE-style result word.
//  - Sits between the mantissa multiplier and the result bus; valid/ready on both sides.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_round_rne.sv | 24 ++
 rtl/fp_mul_round_pipe.sv | 118 +++++++++++
 tb/tb_fp_mul_round_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: single-precision defaults, stage-1 bundle layout,
// and builders for signed infinity / signed zero result words.
`ifndef FP_PKG_DEFS
`define FP_PKG_DEFS
`define FP_INF(s, ew, mw)  {(s), {(ew){1'b1}}, {(mw){1'b0}}}
`define FP_ZERO(s, ew, mw) {(s), {(ew){1'b0}}, {(mw){1'b0}}}
`endif

package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  // Stage-1 bundle at the default format; the pipeline registers follow this field order.
  typedef struct packed {
    logic                       sign;
    logic                       zero;
    logic signed [FP_EXP_W+1:0] e1;
    logic [FP_MAN_W-1:0]        man;
    logic                       guard;
    logic                       sticky;
  } s1_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised mantissa with carry into the exponent.
// Combinational; no handshake.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0]        man,
  input  logic                    guard,
  input  logic                    sticky,
  input  logic signed [EXP_W+1:0] e1,
  output logic [MAN_W-1:0]        m,
  output logic signed [EXP_W+1:0] e2,
  output logic                    inexact
);
  logic           rnd;
  logic [MAN_W:0] sum;

  assign rnd     = guard & (sticky | man[0]);
  assign sum     = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
  // A carry means the mantissa rolled over to 2.0, so renormalise into the exponent.
  assign m       = sum[MAN_W] ? '0 : sum[MAN_W-1:0];
  assign e2      = e1 + {{(EXP_W+1){1'b0}}, sum[MAN_W]};
  assign inexact = guard | sticky;
endmodule

// File: rtl/fp_mul_round_pipe.sv
// FP multiplier result stage: normalise, RNE round, re-bias, ovf/unf, pack. Latency 2.
// Valid/ready on both sides, 1 beat/cycle; a stalled output holds and backs up into stage 1.
module fp_mul_round_pipe import fp_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int BIAS  = FP_BIAS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*MAN_W+1:0]     in_prod,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic                   in_sign_a,
  input  logic                   in_sign_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_inexact
);
  localparam logic [EXP_W+1:0]        BIAS_V = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX   = (EXP_W+2)'((1 << EXP_W) - 1);

  logic                    s1_valid, s1_advance;
  logic                    s1_sign, s1_zero, s1_guard, s1_sticky;
  logic signed [EXP_W+1:0] s1_e1;
  logic [MAN_W-1:0]        s1_man;

  logic                    norm;
  logic [2*MAN_W:0]        p;
  logic signed [EXP_W+1:0] e1_d;

  logic [MAN_W-1:0]        m;
  logic signed [EXP_W+1:0] e2;
  logic                    inexact;
  logic [EXP_W+MAN_W:0]    res_d;
  logic                    ovf_d, unf_d, inx_d;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // Product lies in [1,4); the top bit decides whether a one-place left shift is needed.
  assign norm = in_prod[2*MAN_W+1];
  assign p    = norm ? in_prod[2*MAN_W:0] : {in_prod[2*MAN_W-1:0], 1'b0};
  assign e1_d = in_exp + {{(EXP_W+1){1'b0}}, norm} + BIAS_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_e1     <= '0;
      s1_man    <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= in_sign_a ^ in_sign_b;
        s1_zero   <= (in_prod == '0);
        s1_e1     <= e1_d;
        s1_man    <= p[2*MAN_W:MAN_W+1];
        s1_guard  <= p[MAN_W];
        s1_sticky <= |p[MAN_W-1:0];
      end
    end
  end

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .man     (s1_man),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .e1      (s1_e1),
    .m       (m),
    .e2      (e2),
    .inexact (inexact)
  );

  always_comb begin
    res_d = {s1_sign, e2[EXP_W-1:0], m};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = inexact;
    if (s1_zero) begin
      res_d = `FP_ZERO(s1_sign, EXP_W, MAN_W);
      inx_d = 1'b0;
    end else if (e2 >= EMAX) begin
      res_d = `FP_INF(s1_sign, EXP_W, MAN_W);
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e2[EXP_W+1] || e2 == '0) begin
      // No subnormals: anything at or below the minimum biased exponent flushes to zero.
      res_d = `FP_ZERO(s1_sign, EXP_W, MAN_W);
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= res_d;
        out_ovf     <= ovf_d;
        out_unf     <= unf_d;
        out_inexact <= inx_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_round_pipe.sv
// Directed table-driven bench for fp_mul_round_pipe at single-precision defaults.
module tb_fp_mul_round_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [47:0] in_prod = '0;
  logic [9:0]  in_exp = '0;
  logic        in_sign_a = 1'b0, in_sign_b = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_inexact;

  always #5 clk = ~clk;

  fp_mul_round_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_exp(in_exp), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  typedef struct {
    string       name;
    logic [47:0] prod;
    logic [9:0]  exp;
    logic        sa, sb;
    logic [31:0] res;
    logic        ovf, unf, inx;
  } vec_t;

  vec_t tbl[$];
  vec_t inq[$];
  vec_t expq[$];
  int   total = 0, bad = 0;
  int   acc_before_block;
  int   cyc;

  localparam logic [47:0] ONE = 48'h4000_0000_0000;
  localparam logic [47:0] ALL = 48'hFFFF_FF80_0000;

  function automatic vec_t mk(input string name, input logic [47:0] prod, input logic [9:0] exp,
                              input logic sa, input logic sb, input logic [31:0] res,
                              input logic ovf, input logic unf, input logic inx);
    vec_t v;
    v.name = name; v.prod = prod; v.exp = exp; v.sa = sa; v.sb = sb;
    v.res = res; v.ovf = ovf; v.unf = unf; v.inx = inx;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_prod = v.prod; in_exp = v.exp; in_sign_a = v.sa; in_sign_b = v.sb;
  endtask

  // Streams inq through the DUT; out_ready is low for the first 'stall' cycles.
  task automatic drain(input int stall, input int budget, output int cycles);
    int    c = 0;
    int    acc = 0;
    string nm;
    acc_before_block = -1;
    while ((inq.size() > 0 || expq.size() > 0) && c < budget) begin
      if (inq.size() > 0) begin
        in_valid = 1'b1;
        drive(inq[0]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (c >= stall);
      #1;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected beat", {63'd0, out_valid}, 64'd0);
        end else begin
          nm = expq[0].name;
          if (!out_ready) nm = {nm, " stalled"};
          check(nm, {29'd0, out_result, out_ovf, out_unf, out_inexact},
                {29'd0, expq[0].res, expq[0].ovf, expq[0].unf, expq[0].inx});
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid) begin
        if (in_ready) begin
          expq.push_back(inq.pop_front());
          acc++;
        end else if (acc_before_block < 0) begin
          acc_before_block = acc;
        end
      end
      @(negedge clk);
      c++;
    end
    check("drain timeout", {63'd0, (c >= budget)}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles    = c;
  endtask

  initial begin
    tbl.push_back(mk("1.5x1.5",    48'h9000_0000_0000, 10'h000, 0, 0, 32'h4010_0000, 0, 0, 0));
    tbl.push_back(mk("1x1",        ONE,                10'h000, 0, 0, 32'h3F80_0000, 0, 0, 0));
    tbl.push_back(mk("-1x1",       ONE,                10'h000, 1, 0, 32'hBF80_0000, 0, 0, 0));
    tbl.push_back(mk("-1x-1",      ONE,                10'h000, 1, 1, 32'h3F80_0000, 0, 0, 0));
    tbl.push_back(mk("tie even",   48'h8000_0080_0000, 10'h000, 0, 0, 32'h4000_0000, 0, 0, 1));
    tbl.push_back(mk("tie odd",    48'h8000_0180_0000, 10'h000, 0, 0, 32'h4000_0002, 0, 0, 1));
    tbl.push_back(mk("above half", 48'h8000_00C0_0000, 10'h000, 0, 0, 32'h4000_0001, 0, 0, 1));
    tbl.push_back(mk("below half", 48'h8000_0000_0001, 10'h000, 0, 0, 32'h4000_0000, 0, 0, 1));
    tbl.push_back(mk("shift tie",  48'h4000_0040_0000, 10'h000, 0, 0, 32'h3F80_0000, 0, 0, 1));
    tbl.push_back(mk("carry out",  ALL,                10'h000, 0, 0, 32'h4080_0000, 0, 0, 1));
    tbl.push_back(mk("ovf",        ONE,                10'h080, 0, 0, 32'h7F80_0000, 1, 0, 1));
    tbl.push_back(mk("ovf neg",    ONE,                10'h080, 1, 0, 32'hFF80_0000, 1, 0, 1));
    tbl.push_back(mk("carry ovf",  ALL,                10'h07E, 0, 0, 32'h7F80_0000, 1, 0, 1));
    tbl.push_back(mk("emax",       ONE,                10'h07F, 0, 0, 32'h7F00_0000, 0, 0, 0));
    tbl.push_back(mk("emin",       ONE,                10'h382, 0, 0, 32'h0080_0000, 0, 0, 0));
    tbl.push_back(mk("unf",        ONE,                10'h381, 0, 0, 32'h0000_0000, 0, 1, 1));
    tbl.push_back(mk("unf neg",    ONE,                10'h381, 0, 1, 32'h8000_0000, 0, 1, 1));
    tbl.push_back(mk("deep unf",   ONE,                10'h338, 0, 0, 32'h0000_0000, 0, 1, 1));
    tbl.push_back(mk("zero neg",   48'h0,              10'h000, 1, 0, 32'h8000_0000, 0, 0, 0));
    tbl.push_back(mk("zero hi exp",48'h0,              10'h080, 0, 0, 32'h0000_0000, 0, 0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset result", {29'd0, out_result, out_ovf, out_unf, out_inexact}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Single-beat latency
    drive(tbl[0]);
    in_valid = 1'b1;
    #1;
    check("lat accept", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat cycle1 out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("lat cycle2 out_valid", {63'd0, out_valid}, 64'd1);
    check("lat result", {29'd0, out_result, out_ovf, out_unf, out_inexact},
          {29'd0, 32'h4010_0000, 3'b000});
    @(negedge clk);
    #1;
    check("lat drained", {63'd0, out_valid}, 64'd0);
    @(negedge clk);

    // Full table back-to-back at full throughput
    for (int i = 0; i < tbl.size(); i++) inq.push_back(tbl[i]);
    drain(0, 200, cyc);
    check("throughput cycles", 64'(cyc), 64'(tbl.size() + 2));

    // Backpressure: 4 beats, output stalled for 3 cycles
    for (int i = 4; i < 8; i++) inq.push_back(tbl[i]);
    drain(3, 100, cyc);
    check("bp accepted before block", 64'(acc_before_block), 64'd2);
    check("bp leftover", 64'(expq.size()), 64'd0);

    // Longer stall: several held-output cycles
    for (int i = 9; i < 13; i++) inq.push_back(tbl[i]);
    drain(6, 100, cyc);
    check("long stall leftover", 64'(expq.size()), 64'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(tbl[1]);
    in_valid = 1'b1;
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full out_valid", {63'd0, out_valid}, 64'd1);
    check("full in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", {63'd0, out_valid}, 64'd0);
    check("async rst result", {29'd0, out_result, out_ovf, out_unf, out_inexact}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("no stale beat", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    #1;
    check("in_ready post reset", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
